cnn_layer_accel_awe_ce_pixel_seq: RTL and testbench

CNN_LAYER_ACCEL_AWE_CE_PIXEL_SEQ -- requirements
Module: cnn_layer_accel_awe_ce_pixel_seq

---
 rtl/cnn_layer_accel_awe_ce_pixel_seq.sv | 209 ++++++++++++++++++++
 tb/tb_cnn_layer_accel_awe_ce_pixel_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_accel_awe_ce_pixel_seq.sv
`default_nettype none
// ============================================================================
// Module  : cnn_layer_accel_awe_ce_pixel_seq
// Purpose : Walks an output-pixel job (row, column pair, kernel, cycle) and
//           issues one rowbuffer read per iteration. Each read returns two CE
//           words. The low word goes to CE0 two cycles after the read. The
//           high word goes to CE1 three cycles after the read. Both carry
//           row/column/cycle/last-kernel tags.
// Ports   : clk, rst (sync, active-high), start, cfg_num_* (job shape),
//           pause (stalls read issue), rb_rd_en/rb_rd_addr/rb_rd_data
//           (rowbuffer), ce0_*/ce1_* (pixel words + tags), busy, done.
// Revision: 1.0 - initial release
// ============================================================================
module cnn_layer_accel_awe_ce_pixel_seq #(
  parameter int PIXEL_WIDTH    = 16,
  parameter int NUM_CE_PER_AWE = 2
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic [9:0]                                   cfg_num_rows,
  input  logic [9:0]                                   cfg_num_cols,
  input  logic [9:0]                                   cfg_num_kernels,
  input  logic [2:0]                                   cfg_num_cycles,
  input  logic                                         pause,
  output logic                                         rb_rd_en,
  output logic [15:0]                                  rb_rd_addr,
  input  logic [2*PIXEL_WIDTH*NUM_CE_PER_AWE-1:0]      rb_rd_data,
  output logic [PIXEL_WIDTH*NUM_CE_PER_AWE-1:0]        ce0_pixel_dataout,
  output logic [PIXEL_WIDTH*NUM_CE_PER_AWE-1:0]        ce1_pixel_dataout,
  output logic                                         ce0_pixel_dataout_valid,
  output logic                                         ce1_pixel_dataout_valid,
  output logic [31:0]                                  output_row_ce0,
  output logic [31:0]                                  output_row_ce1,
  output logic [31:0]                                  output_col_ce0,
  output logic [31:0]                                  output_col_ce1,
  output logic                                         ce0_last_kernel,
  output logic                                         ce1_last_kernel,
  output logic [2:0]                                   ce0_cycle_counter,
  output logic [2:0]                                   ce1_cycle_counter,
  output logic                                         busy,
  output logic                                         done
);

  localparam int CEW = PIXEL_WIDTH * NUM_CE_PER_AWE;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  // Latched job shape
  logic [9:0]  r_rows, r_kern, r_cols, r_pairs;
  logic [2:0]  r_cycles;
  // Loop counters and read address
  logic [2:0]  r_c;
  logic [9:0]  r_k, r_j, r_r;
  logic [15:0] r_addr;

  // Stage 1: read in flight, data appears on rb_rd_data this cycle
  logic        r_s1_v, r_s1_lk, r_s1_has1;
  logic [9:0]  r_s1_row, r_s1_j;
  logic [2:0]  r_s1_c;
  // Stage 2: high word and tags waiting one cycle for CE1
  logic        r_s2_has1, r_s2_lk;
  logic [9:0]  r_s2_row, r_s2_j;
  logic [2:0]  r_s2_c;
  logic [CEW-1:0] r_s2_hi;
  // Stage 3: slot occupancy of the CE1 stage (set even when CE1 is masked)
  logic        r_s3_v;

  // Output registers
  logic [CEW-1:0] r_ce0_data, r_ce1_data;
  logic        r_ce0_v, r_ce1_v, r_ce0_lk, r_ce1_lk;
  logic [9:0]  r_ce0_row, r_ce1_row;
  logic [10:0] r_ce0_col, r_ce1_col;
  logic [2:0]  r_ce0_c, r_ce1_c;

  logic        w_issue, w_last_c, w_last_k, w_last_j, w_last_r, w_last_read;
  logic        w_cfg_zero, w_pipe_empty, w_accept, w_has1;
  logic [10:0] w_cols_p1;

  assign w_cols_p1    = {1'b0, cfg_num_cols} + 11'd1;
  assign w_cfg_zero   = (cfg_num_rows == 10'd0) || (cfg_num_cols == 10'd0) ||
                        (cfg_num_kernels == 10'd0) || (cfg_num_cycles == 3'd0);
  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_issue      = (r_state == S_RUN) && !pause;
  assign w_last_c     = (r_c == r_cycles - 3'd1);
  assign w_last_k     = (r_k == r_kern - 10'd1);
  assign w_last_j     = (r_j == r_pairs - 10'd1);
  assign w_last_r     = (r_r == r_rows - 10'd1);
  assign w_last_read  = w_issue && w_last_c && w_last_k && w_last_j && w_last_r;
  // Odd column 2j+1 exists only if it lies inside the configured width
  assign w_has1       = ({r_j, 1'b1} < {1'b0, r_cols});
  assign w_pipe_empty = !(r_s1_v || r_ce0_v || r_s3_v);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = w_cfg_zero ? S_DRAIN : S_RUN;
      S_RUN:   if (w_last_read) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_pipe_empty) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rows   <= '0; r_cols <= '0; r_kern <= '0; r_pairs <= '0; r_cycles <= '0;
      r_c      <= '0; r_k <= '0; r_j <= '0; r_r <= '0; r_addr <= '0;
      r_s1_v   <= 1'b0; r_s1_lk <= 1'b0; r_s1_has1 <= 1'b0;
      r_s1_row <= '0; r_s1_j <= '0; r_s1_c <= '0;
      r_s2_has1 <= 1'b0; r_s2_lk <= 1'b0; r_s2_row <= '0; r_s2_j <= '0;
      r_s2_c   <= '0; r_s2_hi <= '0; r_s3_v <= 1'b0;
      r_ce0_data <= '0; r_ce1_data <= '0; r_ce0_v <= 1'b0; r_ce1_v <= 1'b0;
      r_ce0_lk <= 1'b0; r_ce1_lk <= 1'b0; r_ce0_row <= '0; r_ce1_row <= '0;
      r_ce0_col <= '0; r_ce1_col <= '0; r_ce0_c <= '0; r_ce1_c <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_rows   <= cfg_num_rows;
        r_cols   <= cfg_num_cols;
        r_kern   <= cfg_num_kernels;
        r_cycles <= cfg_num_cycles;
        r_pairs  <= w_cols_p1[10:1];
        r_c <= '0; r_k <= '0; r_j <= '0; r_r <= '0; r_addr <= '0;
      end else if (w_issue) begin
        r_addr <= r_addr + 16'd1;
        if (!w_last_c) begin
          r_c <= r_c + 3'd1;
        end else begin
          r_c <= '0;
          if (!w_last_k) begin
            r_k <= r_k + 10'd1;
          end else begin
            r_k <= '0;
            if (!w_last_j) begin
              r_j <= r_j + 10'd1;
            end else begin
              r_j <= '0;
              r_r <= r_r + 10'd1;
            end
          end
        end
      end

      // Stage 1: tag the read being issued
      r_s1_v <= w_issue;
      if (w_issue) begin
        r_s1_row  <= r_r;
        r_s1_j    <= r_j;
        r_s1_c    <= r_c;
        r_s1_lk   <= w_last_k;
        r_s1_has1 <= w_has1;
      end

      // Stage 2: CE0 output from the low word, park the high word for CE1
      r_ce0_v <= r_s1_v;
      if (r_s1_v) begin
        r_ce0_data <= rb_rd_data[CEW-1:0];
        r_ce0_row  <= r_s1_row;
        r_ce0_col  <= {r_s1_j, 1'b0};
        r_ce0_c    <= r_s1_c;
        r_ce0_lk   <= r_s1_lk;
        r_s2_hi    <= rb_rd_data[2*CEW-1:CEW];
        r_s2_row   <= r_s1_row;
        r_s2_j     <= r_s1_j;
        r_s2_c     <= r_s1_c;
        r_s2_lk    <= r_s1_lk;
        r_s2_has1  <= r_s1_has1;
      end

      // Stage 3: CE1 output, suppressed for a pair with no odd column
      r_s3_v  <= r_ce0_v;
      r_ce1_v <= r_ce0_v && r_s2_has1;
      if (r_ce0_v && r_s2_has1) begin
        r_ce1_data <= r_s2_hi;
        r_ce1_row  <= r_s2_row;
        r_ce1_col  <= {r_s2_j, 1'b1};
        r_ce1_c    <= r_s2_c;
        r_ce1_lk   <= r_s2_lk;
      end
    end
  end

  assign rb_rd_en                = w_issue;
  assign rb_rd_addr              = r_addr;
  assign busy                    = (r_state != S_IDLE);
  assign done                    = (r_state == S_DRAIN) && w_pipe_empty;
  assign ce0_pixel_dataout       = r_ce0_data;
  assign ce1_pixel_dataout       = r_ce1_data;
  assign ce0_pixel_dataout_valid = r_ce0_v;
  assign ce1_pixel_dataout_valid = r_ce1_v;
  assign output_row_ce0          = {22'd0, r_ce0_row};
  assign output_row_ce1          = {22'd0, r_ce1_row};
  assign output_col_ce0          = {21'd0, r_ce0_col};
  assign output_col_ce1          = {21'd0, r_ce1_col};
  assign ce0_last_kernel         = r_ce0_lk;
  assign ce1_last_kernel         = r_ce1_lk;
  assign ce0_cycle_counter       = r_ce0_c;
  assign ce1_cycle_counter       = r_ce1_c;

endmodule
`default_nettype wire

// File: tb/tb_cnn_layer_accel_awe_ce_pixel_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_cnn_layer_accel_awe_ce_pixel_seq
// Purpose : Directed and randomized jobs checked cycle by cycle against a
//           job-level reference model (expected read list plus output timing).
// Revision: 1.0 - initial release
// ============================================================================
module tb_cnn_layer_accel_awe_ce_pixel_seq;

  localparam int CEW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, pause;
  logic [9:0] cfg_num_rows, cfg_num_cols, cfg_num_kernels;
  logic [2:0] cfg_num_cycles;
  logic rb_rd_en;
  logic [15:0] rb_rd_addr;
  logic [2*CEW-1:0] rb_rd_data;
  logic [CEW-1:0] ce0_pixel_dataout, ce1_pixel_dataout;
  logic ce0_pixel_dataout_valid, ce1_pixel_dataout_valid;
  logic [31:0] output_row_ce0, output_row_ce1, output_col_ce0, output_col_ce1;
  logic ce0_last_kernel, ce1_last_kernel;
  logic [2:0] ce0_cycle_counter, ce1_cycle_counter;
  logic busy, done;

  cnn_layer_accel_awe_ce_pixel_seq #(.PIXEL_WIDTH(16), .NUM_CE_PER_AWE(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_num_rows(cfg_num_rows), .cfg_num_cols(cfg_num_cols),
    .cfg_num_kernels(cfg_num_kernels), .cfg_num_cycles(cfg_num_cycles),
    .pause(pause), .rb_rd_en(rb_rd_en), .rb_rd_addr(rb_rd_addr),
    .rb_rd_data(rb_rd_data),
    .ce0_pixel_dataout(ce0_pixel_dataout), .ce1_pixel_dataout(ce1_pixel_dataout),
    .ce0_pixel_dataout_valid(ce0_pixel_dataout_valid),
    .ce1_pixel_dataout_valid(ce1_pixel_dataout_valid),
    .output_row_ce0(output_row_ce0), .output_row_ce1(output_row_ce1),
    .output_col_ce0(output_col_ce0), .output_col_ce1(output_col_ce1),
    .ce0_last_kernel(ce0_last_kernel), .ce1_last_kernel(ce1_last_kernel),
    .ce0_cycle_counter(ce0_cycle_counter), .ce1_cycle_counter(ce1_cycle_counter),
    .busy(busy), .done(done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: the job as a list of reads, plus per-cycle history
  typedef struct {
    int row; int col; int c; bit lk; bit has1;
  } rd_t;
  rd_t        q[$];
  rd_t        iss[0:8191];
  bit         iss_v[0:8191];
  logic [2*CEW-1:0] dat[0:8191];
  logic [15:0] m_addr = '0;
  int  m_done_cyc = -1;
  int  rst_cyc    = -1;
  int  n_issued   = 0;
  bit  m_busy     = 1'b0;
  // Expected (held) output values
  logic [CEW-1:0] e0_data = '0, e1_data = '0;
  int  e0_row = 0, e0_col = 0, e0_c = 0, e1_row = 0, e1_col = 0, e1_c = 0;
  bit  e0_lk = 1'b0, e1_lk = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic cycle(input bit st, input bit ps, input bit rs);
    bit exp_en, e0v, e1v, busy_now;
    int t;
    start = st; pause = ps; rst = rs;
    rb_rd_data = {$urandom, $urandom};
    dat[cyc] = rb_rd_data;
    #1;
    exp_en = (q.size() > 0) && !ps;
    e0v = 1'b0;
    t = cyc - 2;
    if (t >= 0 && t > rst_cyc && iss_v[t]) begin
      e0v = 1'b1; e0_data = dat[t+1][CEW-1:0];
      e0_row = iss[t].row; e0_col = iss[t].col; e0_c = iss[t].c; e0_lk = iss[t].lk;
    end
    e1v = 1'b0;
    t = cyc - 3;
    if (t >= 0 && t > rst_cyc && iss_v[t] && iss[t].has1) begin
      e1v = 1'b1; e1_data = dat[t+1][2*CEW-1:CEW];
      e1_row = iss[t].row; e1_col = iss[t].col + 1; e1_c = iss[t].c; e1_lk = iss[t].lk;
    end
    chk("rd_en", rb_rd_en, exp_en);
    if (exp_en) chk("rd_addr", rb_rd_addr, m_addr);
    chk("busy", busy, m_busy);
    chk("done", done, cyc == m_done_cyc);
    chk("ce0_valid", ce0_pixel_dataout_valid, e0v);
    chk("ce0_data", ce0_pixel_dataout, e0_data);
    chk("ce0_row", output_row_ce0, e0_row);
    chk("ce0_col", output_col_ce0, e0_col);
    chk("ce0_cyc", ce0_cycle_counter, e0_c);
    chk("ce0_lk", ce0_last_kernel, e0_lk);
    chk("ce1_valid", ce1_pixel_dataout_valid, e1v);
    chk("ce1_data", ce1_pixel_dataout, e1_data);
    chk("ce1_row", output_row_ce1, e1_row);
    chk("ce1_col", output_col_ce1, e1_col);
    chk("ce1_cyc", ce1_cycle_counter, e1_c);
    chk("ce1_lk", ce1_last_kernel, e1_lk);

    busy_now = m_busy;
    if (exp_en) begin
      iss_v[cyc] = 1'b1;
      iss[cyc] = q.pop_front();
      m_addr++;
      n_issued++;
      if (q.size() == 0) m_done_cyc = cyc + 4;
    end
    if (cyc == m_done_cyc) m_busy = 1'b0;
    if (rs) begin
      q.delete(); m_busy = 1'b0; m_addr = '0; rst_cyc = cyc; m_done_cyc = -1;
      e0_data = '0; e1_data = '0; e0_row = 0; e0_col = 0; e0_c = 0; e0_lk = 1'b0;
      e1_row = 0; e1_col = 0; e1_c = 0; e1_lk = 1'b0;
    end else if (st && !busy_now) begin
      m_busy = 1'b1; m_addr = '0; n_issued = 0;
      if (cfg_num_rows == 0 || cfg_num_cols == 0 || cfg_num_kernels == 0 ||
          cfg_num_cycles == 0) begin
        m_done_cyc = cyc + 1;
      end else begin
        for (int r = 0; r < int'(cfg_num_rows); r++)
          for (int j = 0; 2*j < int'(cfg_num_cols); j++)
            for (int k = 0; k < int'(cfg_num_kernels); k++)
              for (int c = 0; c < int'(cfg_num_cycles); c++) begin
                rd_t e;
                e.row = r; e.col = 2*j; e.c = c;
                e.lk = (k == int'(cfg_num_kernels) - 1);
                e.has1 = (2*j + 1 < int'(cfg_num_cols));
                q.push_back(e);
              end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One job: optional fixed pause window after p_at reads, optional reset at
  // read number rst_at, optional random pause, optional start pulse while busy.
  task automatic job(input int rows, input int cols, input int kern, input int ncyc,
                     input int p_at, input int p_len, input int rst_at,
                     input bit rnd, input bit poke);
    int pdone = 0;
    int bound = 0;
    bit ps, rs, st;
    cfg_num_rows = rows[9:0]; cfg_num_cols = cols[9:0];
    cfg_num_kernels = kern[9:0]; cfg_num_cycles = ncyc[2:0];
    cycle(1'b1, 1'b0, 1'b0);
    while (m_busy && bound < 3000) begin
      ps = 1'b0; rs = 1'b0;
      st = poke && (bound == 0);
      if (rnd) ps = ($urandom_range(0, 3) == 0);
      else if (q.size() > 0 && n_issued >= p_at && pdone < p_len) begin
        ps = 1'b1; pdone++;
      end
      if (rst_at > 0 && q.size() > 0 && !ps && n_issued == rst_at - 1) rs = 1'b1;
      cycle(st, ps, rs);
      bound++;
    end
    if (m_busy) begin
      total++; bad++;
      $error("FAIL job_timeout cyc=%0d observed=busy expected=idle", cyc);
    end
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; rb_rd_data = '0;
    cfg_num_rows = '0; cfg_num_cols = '0; cfg_num_kernels = '0; cfg_num_cycles = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    // Minimal job, odd-width job, multi-kernel/multi-cycle job
    job(1, 2, 1, 1, 0, 0, 0, 1'b0, 1'b0);
    job(2, 3, 1, 1, 0, 0, 0, 1'b0, 1'b0);
    job(1, 2, 2, 3, 0, 0, 0, 1'b0, 1'b0);
    // Same job paused for 2 cycles after the 2nd read
    job(1, 2, 2, 3, 2, 2, 0, 1'b0, 1'b0);
    // Reset at the 3rd read, then start ignored under reset, then fresh job
    job(2, 4, 1, 2, 0, 0, 3, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    job(1, 2, 1, 2, 0, 0, 0, 1'b0, 1'b0);
    // Empty jobs and a start pulse while busy
    job(3, 3, 0, 2, 0, 0, 0, 1'b0, 1'b0);
    job(0, 3, 2, 2, 0, 0, 0, 1'b0, 1'b0);
    job(2, 3, 2, 0, 0, 0, 0, 1'b0, 1'b0);
    job(2, 5, 2, 2, 0, 0, 0, 1'b0, 1'b1);
    // Randomized shapes with random pause
    for (int n = 0; n < 8; n++)
      job($urandom_range(1, 3), $urandom_range(1, 5), $urandom_range(1, 3),
          $urandom_range(1, 7), 0, 0, 0, 1'b1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
